// File: rtl/matrix_loader.sv
// matrix_loader: writes an 8-bit valid/ready byte stream row-major into the
// 4096-word operand memories MEM_A and/or MEM_B, then pulses load_done.
module matrix_loader #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 12,
    parameter int N_WORDS = 4096
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load_start,
    input  logic [1:0]          load_sel,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic [DATA_W-1:0]   mem_a_wdata,
    output logic [ADDR_W-3:0]   mem_a_addr_hi,
    output logic [1:0]          mem_a_addr_lo,
    output logic                mem_a_nwrt,
    output logic                mem_a_nce,
    output logic [DATA_W-1:0]   mem_b_wdata,
    output logic [ADDR_W-3:0]   mem_b_addr_hi,
    output logic [1:0]          mem_b_addr_lo,
    output logic                mem_b_nwrt,
    output logic                mem_b_nce,
    output logic                busy,
    output logic                load_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   word_cnt;
    logic [1:0]          sel_q;
    logic                hs;
    logic                last_word;
    logic                req_ok;

    assign hs        = in_valid & in_ready;
    assign last_word = (word_cnt == ADDR_W'(N_WORDS - 1));
    assign req_ok    = (state == IDLE) && load_start && (load_sel != 2'b00);
    assign busy      = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    if (load_sel[0])      state_nxt = LOAD_A;
                    else if (load_sel[1]) state_nxt = LOAD_B;
                end
            end
            LOAD_A: begin
                if (hs && last_word) state_nxt = (sel_q == 2'b11) ? LOAD_B : FLUSH;
            end
            LOAD_B: begin
                if (hs && last_word) state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word counter and captured select; the end-of-matrix handshake clears the counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            word_cnt <= '0;
            sel_q    <= 2'b00;
        end else begin
            if (req_ok) begin
                sel_q    <= load_sel;
                word_cnt <= '0;
            end
            if (hs) word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        end
    end

    // Registered handshake, completion and memory write strobes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_ready      <= 1'b0;
            load_done     <= 1'b0;
            mem_a_nce     <= 1'b1;
            mem_a_nwrt    <= 1'b1;
            mem_a_wdata   <= '0;
            mem_a_addr_hi <= '0;
            mem_a_addr_lo <= '0;
            mem_b_nce     <= 1'b1;
            mem_b_nwrt    <= 1'b1;
            mem_b_wdata   <= '0;
            mem_b_addr_hi <= '0;
            mem_b_addr_lo <= '0;
        end else begin
            in_ready   <= (state_nxt == LOAD_A) || (state_nxt == LOAD_B);
            load_done  <= (state == FLUSH);
            mem_a_nce  <= ~(hs && (state == LOAD_A));
            mem_a_nwrt <= ~(hs && (state == LOAD_A));
            mem_b_nce  <= ~(hs && (state == LOAD_B));
            mem_b_nwrt <= ~(hs && (state == LOAD_B));
            if (hs && (state == LOAD_A)) begin
                mem_a_wdata   <= in_data;
                mem_a_addr_hi <= word_cnt[ADDR_W-1:2];
                mem_a_addr_lo <= word_cnt[1:0];
            end
            if (hs && (state == LOAD_B)) begin
                mem_b_wdata   <= in_data;
                mem_b_addr_hi <= word_cnt[ADDR_W-1:2];
                mem_b_addr_lo <= word_cnt[1:0];
            end
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed checks of matrix_loader with a bench-side
// model of MEM_A / MEM_B built from the observed write strobes.
module tb_matrix_loader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        load_start;
    logic [1:0]  load_sel;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  mem_a_wdata;
    logic [9:0]  mem_a_addr_hi;
    logic [1:0]  mem_a_addr_lo;
    logic        mem_a_nwrt;
    logic        mem_a_nce;
    logic [7:0]  mem_b_wdata;
    logic [9:0]  mem_b_addr_hi;
    logic [1:0]  mem_b_addr_lo;
    logic        mem_b_nwrt;
    logic        mem_b_nce;
    logic        busy;
    logic        load_done;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] mem_a [0:4095];
    logic [7:0] mem_b [0:4095];
    logic [7:0] acc   [0:4095];
    int str_a = 0;
    int str_b = 0;

    matrix_loader #(.DATA_W(8), .ADDR_W(12), .N_WORDS(4096)) dut (
        .clk(clk), .rstn(rstn), .load_start(load_start), .load_sel(load_sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_a_wdata(mem_a_wdata), .mem_a_addr_hi(mem_a_addr_hi),
        .mem_a_addr_lo(mem_a_addr_lo), .mem_a_nwrt(mem_a_nwrt), .mem_a_nce(mem_a_nce),
        .mem_b_wdata(mem_b_wdata), .mem_b_addr_hi(mem_b_addr_hi),
        .mem_b_addr_lo(mem_b_addr_lo), .mem_b_nwrt(mem_b_nwrt), .mem_b_nce(mem_b_nce),
        .busy(busy), .load_done(load_done)
    );

    always #5 clk = ~clk;

    // Memory model: a presented strobe is captured at the end of its cycle
    always @(posedge clk) begin
        if (!mem_a_nce && !mem_a_nwrt) begin
            mem_a[{mem_a_addr_hi, mem_a_addr_lo}] = mem_a_wdata;
            str_a = str_a + 1;
        end
        if (!mem_b_nce && !mem_b_nwrt) begin
            mem_b[{mem_b_addr_hi, mem_b_addr_lo}] = mem_b_wdata;
            str_b = str_b + 1;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int base_a, base_b, bad, done_seen, cnt, cyc;
        logic v;

        rstn = 1'b0; load_start = 1'b0; load_sel = 2'b00; in_valid = 1'b0; in_data = '0;
        tick(); tick();
        check_vec("rst_ready", 32'(in_ready), 32'd0);
        check_vec("rst_busy",  32'(busy),     32'd0);
        check_vec("rst_done",  32'(load_done), 32'd0);
        check_vec("rst_strobes", 32'({mem_a_nce, mem_a_nwrt, mem_b_nce, mem_b_nwrt}), 32'hF);
        check_vec("rst_addr_data", 32'({mem_a_addr_hi, mem_a_addr_lo, mem_a_wdata}) |
                                   32'({mem_b_addr_hi, mem_b_addr_lo, mem_b_wdata}), 32'd0);
        rstn = 1'b1;
        tick();

        // Full A then B, continuous stream, in_data = k mod 256
        load_start = 1'b1; load_sel = 2'b11;
        tick();
        load_start = 1'b0;
        check_vec("t1_busy",  32'(busy),     32'd1);
        check_vec("t1_ready", 32'(in_ready), 32'd1);
        base_a = str_a; base_b = str_b; bad = 0; done_seen = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 8192; k++) begin
            logic [11:0] ea;
            ea = 12'(k % 4096);
            in_data = k[7:0];
            tick();
            if (k < 4096) begin
                if (mem_a_nce !== 1'b0 || mem_a_nwrt !== 1'b0 || mem_b_nce !== 1'b1 ||
                    {mem_a_addr_hi, mem_a_addr_lo} !== ea || mem_a_wdata !== k[7:0]) bad++;
            end else begin
                if (mem_b_nce !== 1'b0 || mem_b_nwrt !== 1'b0 || mem_a_nce !== 1'b1 ||
                    {mem_b_addr_hi, mem_b_addr_lo} !== ea || mem_b_wdata !== k[7:0]) bad++;
            end
            if (in_ready !== (k < 8191)) bad++;
            if (load_done) done_seen++;
        end
        in_valid = 1'b0;
        check_vec("t1_stream", 32'(bad), 32'd0);
        check_vec("t1_done_early", 32'(done_seen), 32'd0);
        tick();
        check_vec("t1_done_8194th", 32'(load_done), 32'd1);
        check_vec("t1_busy_at_done", 32'(busy), 32'd0);
        check_vec("t1_idle_strobes", 32'({mem_a_nce, mem_b_nce}), 32'h3);
        tick();
        check_vec("t1_done_single", 32'(load_done), 32'd0);
        check_vec("t1_count_a", 32'(str_a - base_a), 32'd4096);
        check_vec("t1_count_b", 32'(str_b - base_b), 32'd4096);
        check_vec("t1_mem_a_0ff", 32'(mem_a[12'h0FF]), 32'hFF);
        check_vec("t1_mem_a_123", 32'(mem_a[12'h123]), 32'h23);
        check_vec("t1_mem_b_fff", 32'(mem_b[12'hFFF]), 32'hFF);

        // A-only load
        load_start = 1'b1; load_sel = 2'b01;
        tick();
        load_start = 1'b0;
        base_b = str_b; bad = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 4096; k++) begin
            in_data = 8'(k * 3);
            tick();
            if (mem_b_nce !== 1'b1) bad++;
            if (mem_a_nce !== 1'b0 || {mem_a_addr_hi, mem_a_addr_lo} !== 12'(k)) bad++;
        end
        in_valid = 1'b0;
        check_vec("t2_stream", 32'(bad), 32'd0);
        check_vec("t2_ready_drop", 32'(in_ready), 32'd0);
        check_vec("t2_flush_busy", 32'(busy), 32'd1);
        tick();
        check_vec("t2_done_plus2", 32'(load_done), 32'd1);
        check_vec("t2_b_untouched", 32'({mem_b_nce, 31'(str_b - base_b)}), 32'h8000_0000);
        check_vec("t2_mem_a_0ff", 32'(mem_a[12'h0FF]), 32'hFD);

        // load_start=11 in the load_done cycle
        load_start = 1'b1; load_sel = 2'b11;
        tick();
        load_start = 1'b0;
        check_vec("t6_busy", 32'(busy), 32'd1);
        check_vec("t6_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        check_vec("t6_first_write", 32'({mem_a_nce, mem_a_nwrt, mem_a_addr_hi, mem_a_addr_lo, mem_a_wdata}),
                  32'h0005A);

        // Mid-load load_start must not disturb the running load
        bad = 0;
        for (int k = 1; k < 100; k++) begin
            in_data = 8'(k);
            if (k == 50) begin
                load_start = 1'b1; load_sel = 2'b10;
            end else begin
                load_start = 1'b0;
            end
            tick();
            if (mem_a_nce !== 1'b0 || mem_b_nce !== 1'b1 || busy !== 1'b1 ||
                {mem_a_addr_hi, mem_a_addr_lo} !== 12'(k) || mem_a_wdata !== 8'(k)) bad++;
        end
        load_start = 1'b0;
        check_vec("t5_midload_start", 32'(bad), 32'd0);

        // One-cycle reset after 100 bytes; reset beats a simultaneous load_start
        rstn = 1'b0; load_start = 1'b1; load_sel = 2'b11; in_data = 8'hEE;
        tick();
        rstn = 1'b1; load_start = 1'b0;
        check_vec("t4_rst_busy", 32'(busy), 32'd0);
        check_vec("t4_rst_ready", 32'(in_ready), 32'd0);
        check_vec("t4_rst_nce", 32'({mem_a_nce, mem_b_nce, mem_a_nwrt, mem_b_nwrt}), 32'hF);
        check_vec("t4_rst_wdata", 32'(mem_a_wdata), 32'd0);
        load_start = 1'b1; load_sel = 2'b11;
        tick();
        load_start = 1'b0; in_data = 8'hC3;
        tick();
        check_vec("t4_restart_addr0", 32'({mem_a_nce, mem_a_addr_hi, mem_a_addr_lo, mem_a_wdata}),
                  32'h000C3);
        rstn = 1'b0; in_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // load_sel=00 request is ignored
        load_start = 1'b1; load_sel = 2'b00;
        tick();
        load_start = 1'b0;
        check_vec("t5_sel00_busy", 32'(busy), 32'd0);
        check_vec("t5_sel00_ready", 32'(in_ready), 32'd0);
        tick();
        check_vec("t5_sel00_busy2", 32'(busy), 32'd0);

        // B-only load with random idle gaps
        load_start = 1'b1; load_sel = 2'b10;
        tick();
        load_start = 1'b0;
        base_a = str_a; base_b = str_b; bad = 0; cnt = 0; cyc = 0;
        while (cnt < 4096 && cyc < 20000) begin
            v = ($urandom_range(0, 99) >= 30);
            in_valid = v;
            in_data = 8'($urandom);
            if (v) acc[cnt] = in_data;
            tick();
            cyc++;
            if (v) begin
                if (mem_b_nce !== 1'b0 || mem_b_nwrt !== 1'b0 ||
                    {mem_b_addr_hi, mem_b_addr_lo} !== 12'(cnt) || mem_b_wdata !== acc[cnt]) bad++;
                cnt++;
            end else if (mem_b_nce !== 1'b1) begin
                bad++;
            end
            if (mem_a_nce !== 1'b1) bad++;
            if (in_ready !== (cnt < 4096)) bad++;
        end
        in_valid = 1'b0;
        check_vec("t3_accepted", 32'(cnt), 32'd4096);
        check_vec("t3_stream", 32'(bad), 32'd0);
        tick();
        check_vec("t3_done", 32'(load_done), 32'd1);
        check_vec("t3_count_b", 32'(str_b - base_b), 32'd4096);
        check_vec("t3_count_a", 32'(str_a - base_a), 32'd0);
        check_vec("t3_mem_b_abc", 32'(mem_b[12'hABC]), 32'(acc[2748]));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
